// File: rtl/fetch_unit.sv
`timescale 1ns/1ps
// fetch_unit: PC generation + instruction fetch feeding a small in-order queue to decode.
// Latency: word fetched in cycle N is visible on o_id_* in cycle N+1; redirect-to-valid is 2 cycles.
// Backpressure: i_id_ready=0 holds the head stable; fetch stalls once the queue is full.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (misaligned redirect traps into a sticky FAULT state).
module fetch_unit #(
  parameter int               XLEN        = 32,
  parameter logic [XLEN-1:0]  RESET_PC    = '0,
  parameter int               QUEUE_DEPTH = 2
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic [XLEN-1:0] i_imem_inst,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic            o_id_valid,
  output logic [XLEN-1:0] o_id_inst,
  output logic [XLEN-1:0] o_id_pc,
  input  logic            i_id_ready,
  output logic            o_halted,
  output logic            o_fetch_fault
);

  localparam int PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HALT  = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW:0]       count_q, count_d;
  logic [XLEN-1:0]   q_pc_q   [QUEUE_DEPTH];
  logic [XLEN-1:0]   q_pc_d   [QUEUE_DEPTH];
  logic [XLEN-1:0]   q_inst_q [QUEUE_DEPTH];
  logic [XLEN-1:0]   q_inst_d [QUEUE_DEPTH];
  logic              fault_q, fault_d;

  logic              redirect_eff;
  logic              pop;
  logic              can_push;
  logic              push;

  // Next-state: redirect wins over everything, then drain/fetch in RUN, drain only in HALT.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    q_pc_d   = q_pc_q;
    q_inst_d = q_inst_q;
    fault_d  = fault_q;
    push     = 1'b0;

    // Once faulted, redirects no longer have any effect.
    redirect_eff = i_redirect && (state_q != ST_FAULT);
    pop          = (count_q != '0) && i_id_ready && !redirect_eff;
    can_push     = (state_q == ST_RUN) &&
                   ((count_q < (PW+1)'(QUEUE_DEPTH)) || pop) && !redirect_eff;

    if (redirect_eff) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
`ifdef FETCH_MISALIGN_TRAP_EN
      if (i_redirect_pc[1:0] != 2'b00) begin
        state_d = ST_FAULT;
        fault_d = 1'b1;
        pc_d    = i_redirect_pc;
      end else begin
        state_d = ST_RUN;
        pc_d    = i_redirect_pc;
      end
`else
      state_d = ST_RUN;
      pc_d    = i_redirect_pc & ~(XLEN'(3));
`endif
    end else begin
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      if (can_push) begin
        if (i_imem_inst != '0) begin
          push               = 1'b1;
          q_pc_d[wr_ptr_q]   = pc_q;
          q_inst_d[wr_ptr_q] = i_imem_inst;
          wr_ptr_d           = wr_ptr_q + PW'(1);
          pc_d               = pc_q + XLEN'(4);
        end else begin
          // All-zero word is the halt marker: it is never enqueued.
          state_d = ST_HALT;
        end
      end
      count_d = count_q + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

  // State registers, queue storage included.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_RUN;
      pc_q     <= RESET_PC;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      fault_q  <= 1'b0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        q_pc_q[i]   <= '0;
        q_inst_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      fault_q  <= fault_d;
      q_pc_q   <= q_pc_d;
      q_inst_q <= q_inst_d;
    end
  end

  assign o_imem_addr = pc_q;
  assign o_id_valid  = (count_q != '0);
  // Head is read straight from storage; gated so an empty queue shows zeros.
  assign o_id_inst   = o_id_valid ? q_inst_q[rd_ptr_q] : '0;
  assign o_id_pc     = o_id_valid ? q_pc_q[rd_ptr_q]   : '0;
  assign o_halted    = (state_q == ST_HALT);
`ifdef FETCH_MISALIGN_TRAP_EN
  assign o_fetch_fault = fault_q;
`else
  assign o_fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
// tb_fetch_unit: directed plan steps followed by randomized traffic, checked against a queue-based model.
module tb_fetch_unit;

  localparam int DEPTH = 2;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_inst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic        id_ready;
  logic        halted;
  logic        fetch_fault;

  logic [31:0] imem [64];

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [63:0] m_q [$];
  logic [31:0] m_pc;
  int          m_state;   // 0 run, 1 halt, 2 fault
  logic        m_fault;

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .QUEUE_DEPTH(DEPTH)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .o_imem_addr   (imem_addr),
    .i_imem_inst   (imem_inst),
    .i_redirect    (redirect),
    .i_redirect_pc (redirect_pc),
    .o_id_valid    (id_valid),
    .o_id_inst     (id_inst),
    .o_id_pc       (id_pc),
    .i_id_ready    (id_ready),
    .o_halted      (halted),
    .o_fetch_fault (fetch_fault)
  );

  assign imem_inst = imem[imem_addr[7:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("imem_addr", imem_addr, m_pc);
    chk("id_valid", {31'b0, id_valid}, {31'b0, m_q.size() != 0});
    if (m_q.size() != 0) begin
      chk("id_pc", id_pc, m_q[0][63:32]);
      chk("id_inst", id_inst, m_q[0][31:0]);
    end
    chk("halted", {31'b0, halted}, {31'b0, m_state == 1});
    chk("fetch_fault", {31'b0, fetch_fault}, {31'b0, m_fault});
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pc    = 32'h0;
    m_state = 0;
    m_fault = 1'b0;
  endtask

  // One cycle of the architectural rules, expressed on the model queue.
  task automatic model_cycle(input logic rdy, input logic rdr, input logic [31:0] rpc);
    logic        rdr_eff;
    logic        do_pop;
    logic        room;
    logic [31:0] word;
    rdr_eff = rdr && (m_state != 2);
    do_pop  = (m_q.size() != 0) && rdy && !rdr_eff;
    room    = (m_q.size() < DEPTH) || do_pop;
    word    = imem[m_pc[7:2]];
    if (rdr_eff) begin
      m_q.delete();
`ifdef FETCH_MISALIGN_TRAP_EN
      if (rpc % 4 != 0) begin
        m_state = 2;
        m_fault = 1'b1;
        m_pc    = rpc;
      end else begin
        m_state = 0;
        m_pc    = rpc;
      end
`else
      m_state = 0;
      m_pc    = rpc - (rpc % 4);
`endif
    end else begin
      if (do_pop) void'(m_q.pop_front());
      if (m_state == 0 && room) begin
        if (word != 0) begin
          m_q.push_back({m_pc, word});
          m_pc = m_pc + 32'd4;
        end else begin
          m_state = 1;
        end
      end
    end
  endtask

  // Drive at negedge, advance one edge, then compare at the following negedge.
  task automatic step(input logic rdy, input logic rdr, input logic [31:0] rpc);
    id_ready    = rdy;
    redirect    = rdr;
    redirect_pc = rpc;
    @(posedge clk);
    model_cycle(rdy, rdr, rpc);
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    #1;
    rst_n    = 1'b0;
    redirect = 1'b0;
    id_ready = 1'b0;
    model_reset();
    #1;
    check_all();
    chk("rst_id_inst", id_inst, 32'h0);
    chk("rst_id_pc", id_pc, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    check_all();
  endtask

  task automatic load_plan_mem();
    for (int i = 0; i < 64; i++) imem[i] = 32'h0051_0013 + 32'(i) * 32'h100;
    imem[0] = 32'h0010_8113;
    imem[1] = 32'h0010_8193;
    imem[2] = 32'h0031_0233;
    imem[3] = 32'h0041_8293;
    imem[4] = 32'h0000_0000;
  endtask

  initial begin
    rst_n       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    id_ready    = 1'b0;
    load_plan_mem();

    // Sequential fetch with decode always ready
    do_reset();
    step(1'b1, 1'b0, 32'h0);
    chk("seq_pc0", id_pc, 32'h0);
    chk("seq_inst0", id_inst, 32'h0010_8113);
    step(1'b1, 1'b0, 32'h0);
    chk("seq_pc4", id_pc, 32'h4);
    step(1'b1, 1'b0, 32'h0);
    chk("seq_pc8", id_pc, 32'h8);
    chk("seq_inst8", id_inst, 32'h0031_0233);

    // Stall fills the queue, then release drains in order into the halt word
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'h0);
    chk("stall_addr", imem_addr, 32'h8);
    chk("stall_head_pc", id_pc, 32'h0);
    chk("stall_head_inst", id_inst, 32'h0010_8113);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'h0);
    chk("halt_flag", {31'b0, halted}, 32'h1);
    chk("halt_addr", imem_addr, 32'h10);
    chk("halt_drained", {31'b0, id_valid}, 32'h0);

    // Redirect with a full, stalled queue
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h4);
    chk("rdr_flush", {31'b0, id_valid}, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    chk("rdr_valid", {31'b0, id_valid}, 32'h1);
    chk("rdr_pc", id_pc, 32'h4);

    // Redirect out of HALT
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 32'h0);
    chk("halt2", {31'b0, halted}, 32'h1);
    step(1'b1, 1'b1, 32'h0);
    chk("unhalt", {31'b0, halted}, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    chk("resume_pc", id_pc, 32'h0);

    // PC wraps from the top of the address space
    step(1'b1, 1'b1, 32'hFFFF_FFFC);
    step(1'b1, 1'b0, 32'h0);
    chk("wrap_addr", imem_addr, 32'h0);
    chk("wrap_pc", id_pc, 32'hFFFF_FFFC);

    // Misaligned redirect target
    step(1'b1, 1'b1, 32'h6);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("mis_fault", {31'b0, fetch_fault}, 32'h1);
    chk("mis_valid", {31'b0, id_valid}, 32'h0);
    step(1'b1, 1'b1, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    chk("mis_sticky", {31'b0, fetch_fault}, 32'h1);
    chk("mis_ignored", imem_addr, 32'h6);
    chk("mis_no_halt", {31'b0, halted}, 32'h0);
    do_reset();
    chk("mis_cleared", {31'b0, fetch_fault}, 32'h0);
`else
    chk("mis_addr", imem_addr, 32'h4);
    step(1'b1, 1'b0, 32'h0);
    chk("mis_pc", id_pc, 32'h4);
    chk("mis_nofault", {31'b0, fetch_fault}, 32'h0);
`endif

    // Randomized traffic against the model
    for (int n = 0; n < 800; n++) begin
      if (n % 100 == 0) begin
        for (int i = 0; i < 64; i++)
          imem[i] = ($urandom_range(0, 11) == 0) ? 32'h0 : ($urandom | 32'h1);
        imem[0] = 32'h0000_0013;
        do_reset();
      end
      step($urandom_range(0, 9) < 7,
           $urandom_range(0, 15) == 0,
           32'($urandom_range(0, 255)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
